axi_master_port: RTL and testbench
==================================

# axi_master_port

Single-outstanding AXI4 master port that turns a simple valid/ready request interface into single-beat AXI read or write transactions. It carries word-sized reads and strobed writes, and returns one response per request. It sits between a requester (CPU core fetch/LSU side or a small DMA engine) and the AXI bus crossbar, opposite the slave wrappers such as the sensor-controller wrapper.

## Interface
- MASTER_ID, 0: value driven on ARID/AWID (`AXI_ID_BITS wide).
- ACLK  in  1  bus clock; all logic rising-edge.
- ARESETn  in  1  asynchronous, active-low reset.
- req_valid  in  1  requester presents a request.
- req_ready  out  1  port can accept a request (high only in IDLE).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  `AXI_ADDR_BITS  byte address.
- req_wdata  in  `AXI_DATA_BITS  write data.
- req_wstrb  in  `AXI_STRB_BITS  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  `AXI_DATA_BITS  read data; holds its last value otherwise.
- rsp_err  out  1  response was not OKAY; valid with rsp_valid.
- AW channel: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID (out); AWREADY (in).
- W channel: WDATA, WSTRB, WLAST, WVALID (out); WREADY (in).
- B channel: BID, BRESP, BVALID (in); BREADY (out).
- AR channel: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID (out); ARREADY (in).
- R channel: RID, RDATA, RRESP, RLAST, RVALID (in); RREADY (out).
- All AXI widths come from AXI_define.svh.

## Operation
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, go to AR (read) or AW_W (write).
  - AR: ARVALID=1. On ARREADY, go to R.
  - R: RREADY=1. On RVALID&&RLAST, go to IDLE.
  - AW_W: AWVALID/WVALID as described below. When both aw_done and w_done are set, go to B.
  - B: BREADY=1. On BVALID, go to IDLE.
- Request capture: on req_valid&&req_ready, register addr, wdata, wstrb and the write flag. All AXI payload outputs are driven from these registers and stay stable while the corresponding VALID is high.
- Fixed AXI attributes:
  - AxLEN=0, AxSIZE=3'b010, AxBURST=2'b01 (INCR).
  - WLAST=1 whenever WVALID=1.
  - Address is passed unmodified.
- AW_W behaviour:
  - AWVALID and WVALID assert together on entry.
  - Each channel drops on its own handshake, tracked by the aw_done/w_done flags.
  - Handshakes may complete in either order or in the same cycle.
- R beats with RLAST=0: accepted (RREADY stays high) and discarded. Data is taken from the RLAST beat.
- RID and BID are not checked.
- Response:
  - rsp_valid pulses for one cycle on the cycle after the final R or B handshake.
  - rsp_err = (xRESP != 2'b00), latched at that handshake.
  - rsp_rdata is updated only by reads; writes leave it unchanged.
- VALID and READY outputs are decoded purely from registered state. None depends combinationally on an AXI input.

## Timing
- Reset values, asynchronous on ARESETn=0:
  - state=IDLE.
  - All VALID/READY outputs 0 except req_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Captured registers 0.
- Reset mid-transaction: VALIDs drop immediately and no completion is reported. The requester must reissue.
- Read latency with zero-wait slave: accept at edge 0, ARVALID in cycle 1, RREADY in cycle 2, rsp_valid in cycle 3. Minimum 3 cycles.
- Write latency with zero-wait slave: AWVALID+WVALID in cycle 1, BREADY in cycle 2, rsp_valid in cycle 3.
- Each slave wait cycle adds exactly one cycle.
- The rsp_valid cycle coincides with IDLE, so req_ready=1 there. A new request can be accepted in the same cycle the previous response is presented. Back-to-back throughput is one transaction per 3 cycles.
- req_ready is never high while a transaction is outstanding. At most one outstanding transaction.

## Test plan
- Read, zero-wait slave: req addr 0x1000_0100 → ARADDR=0x1000_0100, ARLEN=0, ARSIZE=2, ARID=MASTER_ID. Slave returns RDATA=0xDEADBEEF with RLAST=1 → rsp_valid in cycle 3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write with skewed handshakes: wdata 0x0000_0001, wstrb 4'hF to 0x1000_0200. WREADY arrives 2 cycles before AWREADY → WVALID drops after its handshake, AWVALID holds until its own. BREADY asserts only after both complete. rsp_valid one cycle after the B handshake.
- Stalled read: ARREADY held low for 5 cycles → ARVALID/ARADDR stable throughout. RVALID delayed 3 cycles → rsp_valid exactly 1 cycle after the R handshake.
- Error response: BRESP=2'b10 on a write → rsp_err=1 with rsp_valid, and rsp_rdata unchanged from the prior read.
- Back-to-back: second req_valid held high through the first response → accepted on the rsp_valid cycle. Second ARVALID appears on the next cycle.
- Reset mid-write: ARESETn low during AW_W with AWVALID=1 → AWVALID/WVALID go to 0 immediately, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/axi_master_port_if.sv
// AXI4 five-channel bundle between the master port and the crossbar.
// Latency: wires only, no storage.
// Backpressure: standard VALID/READY on every channel.
`include "AXI_define.svh"

interface axi_master_port_if;
  logic [`AXI_ID_BITS-1:0]    AWID;
  logic [`AXI_ADDR_BITS-1:0]  AWADDR;
  logic [`AXI_LEN_BITS-1:0]   AWLEN;
  logic [`AXI_SIZE_BITS-1:0]  AWSIZE;
  logic [`AXI_BURST_BITS-1:0] AWBURST;
  logic                       AWVALID;
  logic                       AWREADY;

  logic [`AXI_DATA_BITS-1:0]  WDATA;
  logic [`AXI_STRB_BITS-1:0]  WSTRB;
  logic                       WLAST;
  logic                       WVALID;
  logic                       WREADY;

  logic [`AXI_ID_BITS-1:0]    BID;
  logic [`AXI_RESP_BITS-1:0]  BRESP;
  logic                       BVALID;
  logic                       BREADY;

  logic [`AXI_ID_BITS-1:0]    ARID;
  logic [`AXI_ADDR_BITS-1:0]  ARADDR;
  logic [`AXI_LEN_BITS-1:0]   ARLEN;
  logic [`AXI_SIZE_BITS-1:0]  ARSIZE;
  logic [`AXI_BURST_BITS-1:0] ARBURST;
  logic                       ARVALID;
  logic                       ARREADY;

  logic [`AXI_ID_BITS-1:0]    RID;
  logic [`AXI_DATA_BITS-1:0]  RDATA;
  logic [`AXI_RESP_BITS-1:0]  RRESP;
  logic                       RLAST;
  logic                       RVALID;
  logic                       RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/AXI_define.svh
// Shared AXI bus geometry for the master port, its interface and the bench.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ID_BITS    4
`define AXI_ADDR_BITS  32
`define AXI_DATA_BITS  32
`define AXI_STRB_BITS  4
`define AXI_LEN_BITS   8
`define AXI_SIZE_BITS  3
`define AXI_BURST_BITS 2
`define AXI_RESP_BITS  2
`endif

// File: rtl/axi_master_port.sv
// Single-outstanding AXI4 master: one valid/ready request -> one single-beat AXI read or write -> one response pulse.
// Latency: 3 cycles accept-to-rsp_valid with a zero-wait slave, +1 per slave wait cycle.
// Backpressure: req_ready only in IDLE; AXI VALID/READY are registered and hold until their own handshake.
`include "AXI_define.svh"

module axi_master_port #(
  parameter logic [`AXI_ID_BITS-1:0] MASTER_ID = '0
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [`AXI_ADDR_BITS-1:0] req_addr,
  input  logic [`AXI_DATA_BITS-1:0] req_wdata,
  input  logic [`AXI_STRB_BITS-1:0] req_wstrb,
  output logic                      rsp_valid,
  output logic [`AXI_DATA_BITS-1:0] rsp_rdata,
  output logic                      rsp_err,
  axi_master_port_if.master         axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B
  } state_t;

  state_t                    state;
  logic [`AXI_ADDR_BITS-1:0] addr_q;
  logic [`AXI_DATA_BITS-1:0] wdata_q;
  logic [`AXI_STRB_BITS-1:0] wstrb_q;
  logic                      write_q;
  logic                      aw_done;
  logic                      w_done;
  logic                      ar_vld;
  logic                      aw_vld;
  logic                      w_vld;
  logic                      r_rdy;
  logic                      b_rdy;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      unused_ids;

  // Response IDs are not checked: only one transaction is ever in flight.
  assign unused_ids = ^{axi.RID, axi.BID};

  assign aw_hs = aw_vld & axi.AWREADY;
  assign w_hs  = w_vld & axi.WREADY;

  // Payload comes only from the capture registers, so it is stable while VALID is up.
  assign axi.AWID    = MASTER_ID;
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = '0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = aw_vld;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = w_vld;
  assign axi.BREADY  = b_rdy;
  assign axi.ARID    = MASTER_ID;
  assign axi.ARADDR  = addr_q;
  assign axi.ARLEN   = '0;
  assign axi.ARSIZE  = 3'b010;
  assign axi.ARBURST = 2'b01;
  assign axi.ARVALID = ar_vld;
  assign axi.RREADY  = r_rdy;

  // Transaction FSM; every VALID/READY and response output is a register set on the transition into its state.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ar_vld    <= 1'b0;
      aw_vld    <= 1'b0;
      w_vld     <= 1'b0;
      r_rdy     <= 1'b0;
      b_rdy     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            write_q   <= req_write;
            req_ready <= 1'b0;
            if (req_write) begin
              state   <= S_AW_W;
              aw_vld  <= 1'b1;
              w_vld   <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state  <= S_AR;
              ar_vld <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (axi.ARREADY) begin
            ar_vld <= 1'b0;
            r_rdy  <= 1'b1;
            state  <= S_R;
          end
        end
        S_R: begin
          // Non-last beats are swallowed with RREADY left high; only the RLAST beat completes.
          if (axi.RVALID && axi.RLAST) begin
            r_rdy     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= |axi.RRESP;
            if (!write_q) begin
              rsp_rdata <= axi.RDATA;
            end
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_AW_W: begin
          if (aw_hs) begin
            aw_vld  <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            w_vld  <= 1'b0;
            w_done <= 1'b1;
          end
          // Either channel may finish first or both in the same cycle.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            b_rdy <= 1'b1;
            state <= S_B;
          end
        end
        S_B: begin
          if (axi.BVALID) begin
            b_rdy     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= |axi.BRESP;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          ar_vld    <= 1'b0;
          aw_vld    <= 1'b0;
          w_vld     <= 1'b0;
          r_rdy     <= 1'b0;
          b_rdy     <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_port.sv
// Bench for axi_master_port: table vectors, hand-written corner sequences and random transactions vs. a latency/response model.
// Latency: the model predicts 3 + slave waits cycles from request accept to rsp_valid.
// Backpressure: the bench acts as the AXI slave and inserts per-channel wait cycles.
`timescale 1ns/1ps
`ifndef AXI_DEFINE_SVH
`include "AXI_define.svh"
`endif

module tb_axi_master_port;

  localparam logic [`AXI_ID_BITS-1:0] MID = `AXI_ID_BITS'(3);

  logic                      ACLK;
  logic                      ARESETn;
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [`AXI_ADDR_BITS-1:0] req_addr;
  logic [`AXI_DATA_BITS-1:0] req_wdata;
  logic [`AXI_STRB_BITS-1:0] req_wstrb;
  logic                      rsp_valid;
  logic [`AXI_DATA_BITS-1:0] rsp_rdata;
  logic                      rsp_err;

  axi_master_port_if axi_if ();

  axi_master_port #(.MASTER_ID(MID)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .axi       (axi_if)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic                      write;
    logic [`AXI_ADDR_BITS-1:0] addr;
    logic [`AXI_DATA_BITS-1:0] wdata;
    logic [`AXI_STRB_BITS-1:0] wstrb;
    logic [`AXI_DATA_BITS-1:0] rdata;
    logic [1:0]                resp;
    int                        ar_wait;
    int                        aw_wait;
    int                        w_wait;
    int                        r_wait;
    int                        b_wait;
    int                        nonlast;
    int                        exp_lat;
    logic                      exp_err;
    logic [`AXI_DATA_BITS-1:0] exp_rdata;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;
  logic [`AXI_DATA_BITS-1:0] mdl_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic [31:0] rdata, input logic [1:0] resp,
                              input int arw, input int aww, input int ww, input int rw, input int bw,
                              input int nl, input int lat, input logic err, input logic [31:0] erd);
    vec_t v;
    v.write = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.rdata = rdata; v.resp = resp;
    v.ar_wait = arw; v.aw_wait = aww; v.w_wait = ww; v.r_wait = rw; v.b_wait = bw; v.nonlast = nl;
    v.exp_lat = lat; v.exp_err = err; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic slave_idle();
    axi_if.ARREADY = 1'b0;
    axi_if.AWREADY = 1'b0;
    axi_if.WREADY  = 1'b0;
    axi_if.RVALID  = 1'b0;
    axi_if.RLAST   = 1'b0;
    axi_if.RRESP   = 2'b00;
    axi_if.RDATA   = $urandom;
    axi_if.RID     = `AXI_ID_BITS'($urandom);
    axi_if.BVALID  = 1'b0;
    axi_if.BRESP   = 2'b00;
    axi_if.BID     = `AXI_ID_BITS'($urandom);
  endtask

  task automatic apply_reset();
    ARESETn   = 1'b0;
    req_valid = 1'b0;
    slave_idle();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
  endtask

  // Issues one request from a negedge, plays the slave, returns at the negedge where rsp_valid is seen.
  task automatic run_txn(input vec_t v, output int lat, output logic err, output logic [31:0] rd,
                         output logic pay_ok, output logic proto_ok);
    int cyc = 1;
    int ar_seen = 0, aw_seen = 0, w_seen = 0, r_seen = 0, b_seen = 0, beats = 0;
    bit ar_hs = 0, aw_hs = 0, w_hs = 0, r_done = 0, b_hs = 0, fin = 0;
    bit last;
    lat = -1; err = 1'b0; rd = '0; pay_ok = 1'b1; proto_ok = 1'b1;
    if (req_ready !== 1'b1) proto_ok = 1'b0;
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    @(negedge ACLK);
    req_valid = 1'b0;
    while (!fin && cyc <= 200) begin
      // Handshakes that completed at the edge just passed.
      if (axi_if.ARREADY) ar_hs = 1;
      if (axi_if.AWREADY) aw_hs = 1;
      if (axi_if.WREADY)  w_hs = 1;
      if (axi_if.RVALID) begin beats++; if (axi_if.RLAST) r_done = 1; end
      if (axi_if.BVALID)  b_hs = 1;
      slave_idle();
      if (rsp_valid === 1'b1) begin
        fin = 1; lat = cyc; err = rsp_err; rd = rsp_rdata;
        if (req_ready !== 1'b1 || axi_if.ARVALID !== 1'b0 || axi_if.AWVALID !== 1'b0 ||
            axi_if.WVALID !== 1'b0 || axi_if.RREADY !== 1'b0 || axi_if.BREADY !== 1'b0) proto_ok = 1'b0;
      end else begin
        if (req_ready !== 1'b0) proto_ok = 1'b0;
        if (v.write) begin
          if (axi_if.AWVALID !== (!aw_hs) || axi_if.WVALID !== (!w_hs) ||
              axi_if.BREADY !== (aw_hs && w_hs && !b_hs) ||
              axi_if.ARVALID !== 1'b0 || axi_if.RREADY !== 1'b0) proto_ok = 1'b0;
        end else begin
          if (axi_if.ARVALID !== (!ar_hs) || axi_if.RREADY !== (ar_hs && !r_done) ||
              axi_if.AWVALID !== 1'b0 || axi_if.WVALID !== 1'b0 || axi_if.BREADY !== 1'b0) proto_ok = 1'b0;
        end
        if (axi_if.ARVALID === 1'b1 &&
            !(axi_if.ARADDR === v.addr && axi_if.ARLEN === '0 && axi_if.ARSIZE === 3'b010 &&
              axi_if.ARBURST === 2'b01 && axi_if.ARID === MID)) pay_ok = 1'b0;
        if (axi_if.AWVALID === 1'b1 &&
            !(axi_if.AWADDR === v.addr && axi_if.AWLEN === '0 && axi_if.AWSIZE === 3'b010 &&
              axi_if.AWBURST === 2'b01 && axi_if.AWID === MID)) pay_ok = 1'b0;
        if (axi_if.WVALID === 1'b1 &&
            !(axi_if.WDATA === v.wdata && axi_if.WSTRB === v.wstrb && axi_if.WLAST === 1'b1)) pay_ok = 1'b0;
        // Slave behaviour for the coming edge.
        if (axi_if.ARVALID === 1'b1) begin axi_if.ARREADY = (ar_seen == v.ar_wait); ar_seen++; end
        if (axi_if.AWVALID === 1'b1) begin axi_if.AWREADY = (aw_seen == v.aw_wait); aw_seen++; end
        if (axi_if.WVALID === 1'b1)  begin axi_if.WREADY  = (w_seen == v.w_wait);   w_seen++;  end
        if (axi_if.RREADY === 1'b1 && !r_done) begin
          if (r_seen >= v.r_wait) begin
            last = (beats == v.nonlast);
            axi_if.RVALID = 1'b1;
            axi_if.RLAST  = last;
            axi_if.RDATA  = last ? v.rdata : $urandom;
            axi_if.RRESP  = last ? v.resp : 2'b00;
          end
          r_seen++;
        end
        if (axi_if.BREADY === 1'b1 && !b_hs) begin
          if (b_seen == v.b_wait) begin axi_if.BVALID = 1'b1; axi_if.BRESP = v.resp; end
          b_seen++;
        end
        @(negedge ACLK);
        cyc++;
      end
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    int lat; logic err; logic [31:0] rd; logic pay_ok; logic proto_ok;
    run_txn(v, lat, err, rd, pay_ok, proto_ok);
    chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({tag, "_rsp_err"}, 64'(err), 64'(v.exp_err));
    chk({tag, "_rsp_rdata"}, 64'(rd), 64'(v.exp_rdata));
    chk({tag, "_payload"}, 64'(pay_ok), 64'(1));
    chk({tag, "_protocol"}, 64'(proto_ok), 64'(1));
    if (lat < 0) begin
      apply_reset();
      mdl_rdata = '0;
    end
  endtask

  vec_t vecs[8];

  initial begin
    bit saw_rsp;
    vec_t v;
    ARESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    slave_idle();
    mdl_rdata = '0;

    //                wr    addr          wdata         strb   rdata         resp  arw aww ww rw bw nl lat err exp_rdata
    vecs[0] = mk(1'b0, 32'h1000_0100, 32'h0,        4'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0, 3, 1'b0, 32'hDEAD_BEEF);
    vecs[1] = mk(1'b1, 32'h1000_0200, 32'h0000_0001, 4'hF, 32'h0,        2'b00, 0, 2, 0, 0, 0, 0, 5, 1'b0, 32'hDEAD_BEEF);
    vecs[2] = mk(1'b0, 32'h1000_0300, 32'h0,        4'h0, 32'h1234_5678, 2'b00, 5, 0, 0, 3, 0, 0, 11, 1'b0, 32'h1234_5678);
    vecs[3] = mk(1'b1, 32'h1000_0400, 32'hFFFF_0000, 4'h3, 32'h0,        2'b10, 0, 0, 0, 0, 0, 0, 3, 1'b1, 32'h1234_5678);
    vecs[4] = mk(1'b0, 32'h1000_0500, 32'h0,        4'h0, 32'hA5A5_5A5A, 2'b00, 0, 0, 0, 0, 0, 2, 5, 1'b0, 32'hA5A5_5A5A);
    vecs[5] = mk(1'b0, 32'h1000_0600, 32'h0,        4'h0, 32'hCAFE_F00D, 2'b10, 0, 0, 0, 0, 0, 0, 3, 1'b1, 32'hCAFE_F00D);
    vecs[6] = mk(1'b1, 32'h1000_0700, 32'h0BAD_CAFE, 4'h5, 32'h0,        2'b00, 0, 1, 3, 0, 2, 0, 8, 1'b0, 32'hCAFE_F00D);
    vecs[7] = mk(1'b1, 32'h1000_0800, 32'h7777_8888, 4'hC, 32'h0,        2'b11, 0, 1, 1, 0, 0, 0, 4, 1'b1, 32'hCAFE_F00D);

    repeat (2) @(negedge ACLK);
    // Outputs while reset is held.
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_arvalid", 64'(axi_if.ARVALID), 64'(0));
    chk("rst_awvalid", 64'(axi_if.AWVALID), 64'(0));
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("idle_req_ready", 64'(req_ready), 64'(1));
    chk("idle_wvalid", 64'(axi_if.WVALID), 64'(0));
    chk("idle_rready", 64'(axi_if.RREADY), 64'(0));
    chk("idle_bready", 64'(axi_if.BREADY), 64'(0));
    chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("idle_rsp_err", 64'(rsp_err), 64'(0));
    chk("idle_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("idle_araddr", 64'(axi_if.ARADDR), 64'(0));
    chk("idle_wstrb", 64'(axi_if.WSTRB), 64'(0));

    for (int i = 0; i < 8; i++) begin
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back: request held high through the first response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2000_0010;
    @(negedge ACLK);
    chk("b2b_arvalid_1", 64'(axi_if.ARVALID), 64'(1));
    chk("b2b_araddr_1", 64'(axi_if.ARADDR), 64'(32'h2000_0010));
    axi_if.ARREADY = 1'b1;
    req_addr = 32'h2000_0020;
    @(negedge ACLK);
    axi_if.ARREADY = 1'b0;
    chk("b2b_rready", 64'(axi_if.RREADY), 64'(1));
    chk("b2b_req_ready_busy", 64'(req_ready), 64'(0));
    axi_if.RVALID = 1'b1; axi_if.RLAST = 1'b1; axi_if.RDATA = 32'h1111_2222; axi_if.RRESP = 2'b00;
    @(negedge ACLK);
    slave_idle();
    chk("b2b_rsp_valid_1", 64'(rsp_valid), 64'(1));
    chk("b2b_req_ready_rsp", 64'(req_ready), 64'(1));
    chk("b2b_rdata_1", 64'(rsp_rdata), 64'(32'h1111_2222));
    @(negedge ACLK);
    req_valid = 1'b0;
    chk("b2b_arvalid_2", 64'(axi_if.ARVALID), 64'(1));
    chk("b2b_araddr_2", 64'(axi_if.ARADDR), 64'(32'h2000_0020));
    chk("b2b_rsp_pulse", 64'(rsp_valid), 64'(0));
    axi_if.ARREADY = 1'b1;
    @(negedge ACLK);
    axi_if.ARREADY = 1'b0;
    axi_if.RVALID = 1'b1; axi_if.RLAST = 1'b1; axi_if.RDATA = 32'h3333_4444; axi_if.RRESP = 2'b00;
    @(negedge ACLK);
    slave_idle();
    chk("b2b_rsp_valid_2", 64'(rsp_valid), 64'(1));
    chk("b2b_rdata_2", 64'(rsp_rdata), 64'(32'h3333_4444));
    @(negedge ACLK);

    // Reset in the middle of a write with AWVALID up.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3000_0000; req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF;
    @(negedge ACLK);
    req_valid = 1'b0;
    chk("mid_rst_awvalid_before", 64'(axi_if.AWVALID), 64'(1));
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_awvalid", 64'(axi_if.AWVALID), 64'(0));
    chk("mid_rst_wvalid", 64'(axi_if.WVALID), 64'(0));
    saw_rsp = 0;
    repeat (2) begin @(negedge ACLK); if (rsp_valid) saw_rsp = 1; end
    ARESETn = 1'b1;
    repeat (4) begin @(negedge ACLK); if (rsp_valid) saw_rsp = 1; end
    chk("mid_rst_no_rsp", 64'(saw_rsp), 64'(0));
    chk("mid_rst_req_ready", 64'(req_ready), 64'(1));
    chk("mid_rst_rdata", 64'(rsp_rdata), 64'(0));
    mdl_rdata = '0;

    // Random traffic against the latency/response model.
    for (int i = 0; i < 40; i++) begin
      v.write   = 1'($urandom_range(0, 1));
      v.addr    = $urandom;
      v.wdata   = $urandom;
      v.wstrb   = 4'($urandom_range(0, 15));
      v.rdata   = $urandom;
      v.resp    = 2'($urandom_range(0, 3));
      v.ar_wait = $urandom_range(0, 4);
      v.aw_wait = $urandom_range(0, 4);
      v.w_wait  = $urandom_range(0, 4);
      v.r_wait  = $urandom_range(0, 4);
      v.b_wait  = $urandom_range(0, 4);
      v.nonlast = $urandom_range(0, 2);
      if (v.write) begin
        v.exp_lat = 3 + ((v.aw_wait > v.w_wait) ? v.aw_wait : v.w_wait) + v.b_wait;
      end else begin
        v.exp_lat = 3 + v.ar_wait + v.r_wait + v.nonlast;
        mdl_rdata = v.rdata;
      end
      v.exp_err   = (v.resp != 2'b00);
      v.exp_rdata = mdl_rdata;
      check_vec($sformatf("rnd%0d", i), v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
